// File: rtl/jtdsp16_do_cache_pkg.sv
// Shared DSP16 definitions: loop-cache state encoding, default field widths, do opcode.
package jtdsp16_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    REPLAY = 2'd2
  } state_t;

  // do_data is {NI, K}: NI in the upper NIW bits, K in the lower KW bits
  localparam int DEF_NIW   = 4;
  localparam int DEF_KW    = 7;
  localparam int DEF_DW    = 16;
  localparam int DEF_DEPTH = 15;
  localparam int DEF_AW    = 4;

  localparam logic [4:0] DO_OPCODE = 5'b01110;

endpackage

// File: rtl/jtdsp16_do_cache_if.sv
// Decoder/fetch-side bundle of the DO/REDO loop cache.
interface jtdsp16_do_cache_if
  import jtdsp16_pkg::*;
#(
  parameter int NIW = DEF_NIW,
  parameter int KW  = DEF_KW,
  parameter int DW  = DEF_DW
) ();

  logic              cen;
  logic              do_start;
  logic [NIW+KW-1:0] do_data;
  logic [DW-1:0]     rom_dout;
  logic [DW-1:0]     cache_dout;
  logic              up_xcache;
  logic              pc_hold;
  logic              no_int;
  logic              busy;
  logic [KW-1:0]     iter_left;
  logic              fault;

  modport master (
    output cen, do_start, do_data, rom_dout,
    input  cache_dout, up_xcache, pc_hold, no_int, busy, iter_left, fault
  );

  modport slave (
    input  cen, do_start, do_data, rom_dout,
    output cache_dout, up_xcache, pc_hold, no_int, busy, iter_left, fault
  );

endinterface

// File: rtl/jtdsp16_cache_ram.sv
// DEPTH x DW loop-body store: one write port, one registered read port.
// A read of the word being written returns the new data, so a 1-word body replays correctly.
module jtdsp16_cache_ram #(
  parameter int DEPTH = 15,
  parameter int AW    = 4,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
  end

endmodule

// File: rtl/jtdsp16_do_cache.sv
// DO/REDO loop cache: captures the loop body from ROM on the first pass, then replays it
// from internal storage with the PC frozen; redo replays the stored body again.
module jtdsp16_do_cache
  import jtdsp16_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW,
  parameter int NIW   = DEF_NIW,
  parameter int KW    = DEF_KW,
  parameter int DW    = DEF_DW
) (
  input  logic               clk,
  input  logic               rst,
  jtdsp16_do_cache_if.slave  bus
);

  localparam int CW = (AW > NIW) ? AW : NIW;

  state_t         state, state_n;
  logic [AW-1:0]  wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
  logic [NIW-1:0] ni_stored, ni_n;
  logic [KW-1:0]  iter_left, iter_n;
  logic           fault, fault_n;
  logic           mem_we, mem_re;

  logic [NIW-1:0] ni_in;
  logic [KW-1:0]  k_in;
  logic           ni_over;
  logic [CW-1:0]  ni_last;
  logic           wr_last, rd_last;

  assign ni_in   = bus.do_data[NIW+KW-1:KW];
  assign k_in    = bus.do_data[KW-1:0];
  assign ni_over = int'(ni_in) > DEPTH;
  assign ni_last = CW'(ni_stored) - 1'b1;
  assign wr_last = CW'(wr_ptr) == ni_last;
  assign rd_last = CW'(rd_ptr) == ni_last;

  always_comb begin
    state_n  = state;
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    ni_n     = ni_stored;
    iter_n   = iter_left;
    fault_n  = fault;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    if (bus.cen) begin
      // A new do/redo cannot nest inside an active loop
      if (bus.do_start && state != IDLE) fault_n = 1'b1;
      case (state)
        IDLE: begin
          if (bus.do_start) begin
            if (ni_in != '0) begin
              ni_n     = ni_over ? NIW'(DEPTH) : ni_in;
              iter_n   = (k_in == '0) ? KW'(1) : k_in;
              wr_ptr_n = '0;
              state_n  = LOAD;
              if (ni_over) fault_n = 1'b1;
            end else if (ni_stored == '0) begin
              fault_n = 1'b1;
            end else if (k_in != '0) begin
              iter_n   = k_in;
              rd_ptr_n = '0;
              mem_re   = 1'b1;
              state_n  = REPLAY;
            end
          end
        end
        LOAD: begin
          mem_we   = 1'b1;
          wr_ptr_n = wr_ptr + 1'b1;
          if (wr_last) begin
            iter_n   = iter_left - 1'b1;
            rd_ptr_n = '0;
            if (iter_left != KW'(1)) begin
              mem_re  = 1'b1;
              state_n = REPLAY;
            end else begin
              state_n = IDLE;
            end
          end
        end
        REPLAY: begin
          rd_ptr_n = rd_last ? '0 : rd_ptr + 1'b1;
          mem_re   = 1'b1;
          if (rd_last) begin
            iter_n = iter_left - 1'b1;
            if (iter_left == KW'(1)) begin
              mem_re  = 1'b0;
              state_n = IDLE;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ni_stored <= '0;
      iter_left <= '0;
      fault     <= 1'b0;
    end else begin
      state     <= state_n;
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      ni_stored <= ni_n;
      iter_left <= iter_n;
      fault     <= fault_n;
    end
  end

  // Read address is the next pointer so cache_dout tracks rd_ptr with no bubble
  jtdsp16_cache_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (bus.rom_dout),
    .re    (mem_re),
    .raddr (rd_ptr_n),
    .rdata (bus.cache_dout)
  );

  assign bus.up_xcache = (state == REPLAY);
  assign bus.pc_hold   = (state == REPLAY);
  assign bus.no_int    = (state != IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.iter_left = iter_left;
  assign bus.fault     = fault;

endmodule

// File: tb/tb_jtdsp16_do_cache.sv
// Randomised scoreboard bench for the DO/REDO loop cache (DEPTH=8 so NI clamping is reachable).
module tb_jtdsp16_do_cache;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int NIW   = 4;
  localparam int KW    = 7;
  localparam int DW    = 16;

  logic clk;
  logic rst;

  jtdsp16_do_cache_if #(.NIW(NIW), .KW(KW), .DW(DW)) bus ();

  jtdsp16_do_cache #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .NIW   (NIW),
    .KW    (KW),
    .DW    (DW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard: words the cache must present, in order, on replay cycles
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model_mem[$];
  int            model_ni = 0;
  logic          exp_fault = 1'b0;
  logic [DW-1:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.busy) begin
        chk("pc_hold_vs_xcache", 32'(bus.pc_hold), 32'(bus.up_xcache));
        chk("no_int_when_busy", 32'(bus.no_int), 32'd1);
      end else begin
        chk("idle_outputs", {29'd0, bus.up_xcache, bus.pc_hold, bus.no_int}, 32'd0);
      end
      if (bus.up_xcache && bus.cen) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_replay: got word %0h expected none at %0t", bus.cache_dout, $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("cache_dout", 32'(bus.cache_dout), 32'(mon_e));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int ni, input int k);
    logic [NIW-1:0] nf;
    logic [KW-1:0]  kf;
    nf = NIW'(ni);
    kf = KW'(k);
    bus.do_start = 1'b1;
    bus.do_data  = {nf, kf};
    bus.cen      = 1'b1;
    tick();
    bus.do_start = 1'b0;
    bus.do_data  = (NIW+KW)'($urandom);
  endtask

  task automatic run_replay(input int exp_cnt, input bit cmode, input bit inject);
    int cnt = 0;
    int budget = 0;
    bit injected = 1'b0;
    while (bus.busy && budget < 2000) begin
      bus.cen      = cmode ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.rom_dout = DW'($urandom);
      if (inject && !injected && cnt == 2 && bus.up_xcache) begin
        bus.do_start = 1'b1;
        bus.cen      = 1'b1;
        bus.do_data  = {4'd3, 7'd5};
        injected     = 1'b1;
        exp_fault    = 1'b1;
      end
      if (bus.up_xcache && bus.cen) cnt++;
      tick();
      bus.do_start = 1'b0;
      budget++;
    end
    chk("replay_within_budget", 32'(budget < 2000), 32'd1);
    chk("replay_cycles", 32'(cnt), 32'(exp_cnt));
    chk("iter_left_end", 32'(bus.iter_left), 32'd0);
  endtask

  task automatic do_loop(input int ni, input int k, input bit cmode, input bit inject);
    int n;
    int kk;
    int i;
    int budget;
    logic [DW-1:0] body[$];
    n  = (ni > DEPTH) ? DEPTH : ni;
    kk = (k == 0) ? 1 : k;
    for (int j = 0; j < n; j++) body.push_back(DW'($urandom));
    model_mem = body;
    model_ni  = n;
    if (ni > DEPTH) exp_fault = 1'b1;
    for (int p = 1; p < kk; p++)
      for (int j = 0; j < n; j++) exp_q.push_back(body[j]);
    issue(ni, k);
    chk("do_iter_left", 32'(bus.iter_left), 32'(kk));
    chk("do_busy", 32'(bus.busy), 32'd1);
    i = 0;
    budget = 0;
    while (i < n && budget < 1000) begin
      bus.rom_dout = body[i];
      bus.cen      = cmode ? 1'($urandom_range(0, 1)) : 1'b1;
      chk("load_no_xcache", 32'(bus.up_xcache), 32'd0);
      tick();
      if (bus.cen) i++;
      budget++;
    end
    run_replay(n * (kk - 1), cmode, inject);
    chk("do_fault", 32'(bus.fault), 32'(exp_fault));
  endtask

  task automatic redo(input int k, input bit cmode);
    bit start;
    start = (model_ni != 0) && (k != 0);
    if (model_ni == 0) exp_fault = 1'b1;
    if (start)
      for (int p = 0; p < k; p++)
        for (int j = 0; j < model_ni; j++) exp_q.push_back(model_mem[j]);
    issue(0, k);
    chk("redo_busy", 32'(bus.busy), 32'(start));
    if (start) chk("redo_iter_left", 32'(bus.iter_left), 32'(k));
    run_replay(start ? model_ni * k : 0, cmode, 1'b0);
    chk("redo_fault", 32'(bus.fault), 32'(exp_fault));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.cen = 1'b0;
    tick();
    chk("reset_outputs", {4'd0, bus.cache_dout, bus.up_xcache, bus.pc_hold, bus.no_int,
                          bus.busy, bus.iter_left, bus.fault}, 32'd0);
    rst = 1'b0;
    model_ni  = 0;
    exp_fault = 1'b0;
    exp_q.delete();
    bus.cen = 1'b1;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst          = 1'b0;
    bus.cen      = 1'b0;
    bus.do_start = 1'b0;
    bus.do_data  = '0;
    bus.rom_dout = '0;
    #2;
    do_reset();

    redo(3, 1'b0);
    do_reset();

    do_loop(3, 4, 1'b0, 1'b0);
    redo(2, 1'b0);
    redo(0, 1'b0);
    do_loop(2, 1, 1'b0, 1'b0);
    do_loop(1, 3, 1'b0, 1'b0);
    do_loop(15, 2, 1'b0, 1'b0);
    redo(1, 1'b0);
    do_reset();

    do_loop(3, 4, 1'b1, 1'b0);
    do_loop(4, 3, 1'b0, 1'b1);
    do_reset();

    for (int r = 0; r < 14; r++) begin
      if ($urandom_range(0, 2) == 0)
        redo($urandom_range(0, 4), 1'($urandom_range(0, 1)));
      else
        do_loop($urandom_range(1, DEPTH + 3), $urandom_range(0, 5), 1'($urandom_range(0, 1)), 1'b0);
    end
    do_reset();

    // Asynchronous reset in the middle of LOAD
    issue(5, 2);
    bus.rom_dout = DW'($urandom);
    tick();
    tick();
    chk("midload_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("midload_reset_outputs", {4'd0, bus.cache_dout, bus.up_xcache, bus.pc_hold, bus.no_int,
                                  bus.busy, bus.iter_left, bus.fault}, 32'd0);
    tick();
    rst = 1'b0;
    model_ni  = 0;
    exp_fault = 1'b0;
    exp_q.delete();
    tick();
    redo(2, 1'b0);

    repeat (3) tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jtdsp16_do_cache.md
Name: jtdsp16_do_cache

Overview:
- Parametrised DO/REDO loop cache for the DSP16 core; next-generation replacement for the fixed 15-word cache.
- Sits between the instruction decoder and the XAAU/ROM fetch path.
- On a `do` it captures the loop body from `rom_dout` during the first pass. It then replays the body from internal storage for the remaining iterations while freezing the PC.
- A `redo` replays the previously stored body without refetching.

Parameters:
- DEPTH, 15: cache capacity in 16-bit words.
- AW, 4: pointer width; must satisfy 2^AW >= DEPTH.
- NIW, 4: width of the NI (words in loop) field.
- KW, 7: width of the K (iteration count) field.
- DW, 16: instruction word width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cen  in  1  clock enable; all state advances only when high
- do_start  in  1  decoder strobe: do/redo instruction decoded this cycle
- do_data  in  NIW+KW  {NI, K}; NI in the upper NIW bits, K in the lower KW bits
- rom_dout  in  DW  word from program ROM
- cache_dout  out  DW  word replayed from cache
- up_xcache  out  1  select cache_dout as instruction source
- pc_hold  out  1  freeze the XAAU PC increment
- no_int  out  1  block interrupt acceptance while the loop is active
- busy  out  1  state != IDLE
- iter_left  out  KW  remaining iterations, including the current one
- fault  out  1  sticky error flag

Behaviour:
- Reset values: state=IDLE, wr_ptr=rd_ptr=0, ni_stored=0, iter_left=0, fault=0. All outputs are 0 and cache_dout=0. Memory contents are not reset.
- Outputs are Moore decodes of the registered state:
  - up_xcache = pc_hold = (state==REPLAY)
  - no_int = busy = (state!=IDLE)
- States:
  - IDLE:
    - On cen with do_start and NI!=0 (do): latch ni_stored=min(NI,DEPTH) and iter_left=max(K,1), set wr_ptr=0, go to LOAD.
    - If NI>DEPTH, set fault and clamp NI to DEPTH.
    - On cen with do_start and NI==0 (redo):
      - If ni_stored==0 or K==0: no-op; fault is set only when ni_stored==0.
      - Otherwise set iter_left=K, rd_ptr=0, go to REPLAY.
  - LOAD:
    - On each cen, write mem[wr_ptr]=rom_dout and increment wr_ptr.
    - When wr_ptr==ni_stored-1, decrement iter_left. Go to REPLAY if the decremented value is !=0, else IDLE.
  - REPLAY:
    - cache_dout = mem[rd_ptr], registered; valid in the same cycle the state reads REPLAY (prefetch mem[0] on entry).
    - On each cen, rd_ptr advances.
    - At rd_ptr==ni_stored-1: rd_ptr wraps to 0 and iter_left decrements. When it reaches 0, go to IDLE.
- NI counts cache words, not instructions; a two-word instruction consumes two entries.
- Latency:
  - do with NI=n, K=k occupies n cycles in LOAD plus n*(k-1) cycles in REPLAY.
  - A redo with K=k occupies n*k cycles.
- do_start while busy: ignored, fault=1, loop continues unaffected.
- cen low: every register holds; outputs are stable.
- Reset mid-loop: immediate return to IDLE with all outputs at 0. ni_stored clears, so a following redo faults.
- fault clears only on rst.

Decomposition:
- Shared package jtdsp16_pkg holds:
  - state encoding localparams: IDLE=0, LOAD=1, REPLAY=2
  - NI/K field split constants
  - the do opcode value 5'b01110
- One natural sub-module: jtdsp16_cache_ram, a DEPTH x DW synchronous single-write, single-read RAM with registered read port.

Test Plan:
- do NI=3,K=4; ROM supplies A,B,C after do.
  - 3 LOAD cycles with up_xcache=0.
  - Then 9 REPLAY cycles: cache_dout A,B,C,A,B,C,A,B,C, pc_hold=1.
  - Then IDLE; no_int high for all 12 cycles.
- do NI=2,K=1: 2 LOAD cycles, no REPLAY, up_xcache never asserts, iter_left goes 1->0.
- After the first test, redo K=2: 6 REPLAY cycles A,B,C,A,B,C with no rom_dout sampling. Then redo K=0: no state change, fault=0.
- Redo immediately after reset: stays IDLE, fault=1.
- do NI=15 with DEPTH=8, K=2:
  - fault=1, ni_stored=8.
  - 8 LOAD cycles, then 8 REPLAY cycles with rd_ptr wrapping correctly.
- Interference cases:
  - cen toggling 1/0 throughout a loop: the replay sequence is identical to the continuous case with holds.
  - do_start asserted mid-REPLAY: fault=1, sequence unaffected.
  - rst asserted mid-LOAD: all outputs 0 in the same cycle.
